// File: rtl/poly_modadd_ctrl_pkg.sv
// Shared definitions for the polynomial modular add/sub sequencer:
// coefficient width, FSM state encoding and mode selectors.
package poly_modadd_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/poly_modadd_ctrl_modular_add.sv
// Combinational modular adder: returns (a + b) mod q for operands whose sum is below 2q.
module modular_add
  import poly_modadd_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_q,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // A single conditional subtraction suffices because a + b < 2q; the
  // extra MSB of the difference acts as the borrow flag.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = w_sum - {1'b0, i_q};
  assign o_sum  = w_diff[DATA_W] ? w_sum[DATA_W-1:0] : w_diff[DATA_W-1:0];

endmodule

// File: rtl/poly_modadd_ctrl.sv
// Streams two coefficient vectors through one modular adder, one element per cycle,
// writing (a + b) mod q or (a - b) mod q into the result memory.
module poly_modadd_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = poly_modadd_ctrl_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] q,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  import poly_modadd_ctrl_pkg::*;

  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  state_t              r_state;
  state_t              w_nextState;
  logic                r_mode;
  logic [DATA_W-1:0]   r_q;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W-1:0]   r_rdAddr;
  logic                r_v1;
  logic [ADDR_W-1:0]   r_addr1;
  logic                r_wrEn;
  logic [ADDR_W-1:0]   r_wrAddr;
  logic [DATA_W-1:0]   r_wrData;
  logic                w_accept;
  logic                w_lastRead;
  logic [DATA_W-1:0]   w_bPrep;
  logic [DATA_W-1:0]   w_sum;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_lastRead = ({1'b0, r_rdAddr} == (r_len - LEN_ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // DRAIN ends in the cycle the final write is on the bus, which is the
  // first DRAIN cycle with no operand data arriving from memory.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = (len == '0) ? DONE : RUN;
      RUN:     if (w_lastRead) w_nextState = DRAIN;
      DRAIN:   if (!r_v1) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode   <= MODE_ADD;
      r_q      <= '0;
      r_len    <= '0;
      r_rdAddr <= '0;
    end else if (w_accept) begin
      r_mode   <= mode;
      r_q      <= q;
      r_len    <= len;
      r_rdAddr <= '0;
    end else if (r_state == RUN) begin
      r_rdAddr <= w_lastRead ? '0 : r_rdAddr + 1'b1;
    end
  end

  // Subtraction is done as a + (q - b); b = 0 yields q, which the adder folds back to a.
  assign w_bPrep = (r_mode == MODE_SUB) ? (r_q - b_data) : b_data;

  modular_add u_modAdd (
    .i_a   (a_data),
    .i_b   (w_bPrep),
    .i_q   (r_q),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1     <= 1'b0;
      r_addr1  <= '0;
      r_wrEn   <= 1'b0;
      r_wrAddr <= '0;
      r_wrData <= '0;
    end else begin
      r_v1     <= rd_en;
      r_addr1  <= r_rdAddr;
      r_wrEn   <= r_v1;
      r_wrAddr <= r_addr1;
      if (r_v1) begin
        r_wrData <= w_sum;
      end
    end
  end

  assign rd_en   = (r_state == RUN);
  assign rd_addr = r_rdAddr;
  assign wr_en   = r_wrEn;
  assign wr_addr = r_wrAddr;
  assign wr_data = r_wrData;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);

endmodule

// File: doc/poly_modadd_ctrl.md
# poly_modadd_ctrl

Sequencer that performs element-wise modular addition or subtraction of two coefficient vectors held in single-port-read memories, writing the result vector to a third memory. It owns one instance of the combinational modular adder and streams one coefficient per cycle through it. It sits beside the NTT core and is used for polynomial add/sub between transforms, such as Kyber and Dilithium key generation and encapsulation.

## Interface
Parameters:
- ADDR_W, 8: address width; maximum vector length is 2^ADDR_W.
- DATA_W, 32: coefficient width; fixed to the modular adder width and not meant to be overridden.

Ports:
- clk, input, 1: clock. One clock domain.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle request; sampled only in IDLE.
- mode, input, 1: 0 = add (a+b), 1 = subtract (a−b); latched at start.
- q, input, DATA_W: modulus; latched at start. q[7:0] must equal 8'h01.
- len, input, ADDR_W+1: number of coefficients, 0..2^ADDR_W; latched at start.
- rd_en, output, 1: read strobe to both operand memories.
- rd_addr, output, ADDR_W: read address, shared by memories A and B.
- a_data, input, DATA_W: memory A data; valid 1 cycle after rd_en.
- b_data, input, DATA_W: memory B data; valid 1 cycle after rd_en.
- wr_en, output, 1: result memory write strobe.
- wr_addr, output, ADDR_W: result address.
- wr_data, output, DATA_W: result coefficient, in [0, q).
- busy, output, 1: operation in progress.
- done, output, 1: one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE: wait for start.
  - RUN: issue reads, one address per cycle.
  - DRAIN: wait for in-flight writes to complete.
  - DONE: pulse done for one cycle, then return to IDLE.
- Transitions:
  - IDLE + start, with len≠0 → RUN.
  - IDLE + start, with len=0 → DONE. No reads and no writes are issued.
  - RUN → DRAIN after the read of address len−1 is issued.
  - DRAIN → DONE once the last write has been issued.
  - DONE → IDLE.
- Read counter counts 0..len−1 in RUN and issues rd_en=1 every RUN cycle. No bubbles.
- Pipeline:
  - Stage 1: memory read.
  - Stage 2: operand prep. Add mode passes b through; subtract mode uses b' = q − b, computed at DATA_W bits, so b=0 gives b'=q.
  - Then modular_add(a, b', q), with the result registered into wr_data. The write address is the read address delayed by 2.
- Operand contract: 0 ≤ a, b < q < 2^31, so a+b' < 2q. The adder output is always in [0, q).
- start outside IDLE is ignored. mode, q and len are changed only by a start accepted in IDLE.
- Reset: asynchronous clear of state to IDLE and of all counters, pipeline valids and outputs.
  - Reset mid-operation aborts immediately. No wr_en is issued after reset asserts.
  - Memory contents already written are left as they are.
- Reset values: rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.

## Timing
- start is sampled at edge 0. rd_en is high with rd_addr=i in cycles 1+i, for i = 0..len−1.
- Write of element i happens in cycle 3+i. Latency from read to write is 2 cycles. Throughput is 1 coefficient per cycle.
- done=1 in cycle len+3 only. For len=0, done=1 in cycle 1.
- busy=1 from cycle 1 through the done cycle inclusive, and is 0 from the next cycle.
- A start accepted in the cycle after done begins a new operation with no gap.

## Structure
- Shared package holds:
  - constant DATA_W = 32;
  - the FSM state enum (IDLE, RUN, DRAIN, DONE);
  - constants MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
- One sub-module: the existing combinational `modular_add`, instantiated once.
- All pipeline registers, counters and the FSM live in poly_modadd_ctrl itself.

## Test plan
- Add mode, q=3329, len=4, A={0,1,3328,1664}, B={0,3328,3328,1665} → C={0,0,3327,0}.
  - Writes in cycles 3..6, done in cycle 7.
- Subtract mode, q=3329, len=3, A={5,0,3328}, B={7,0,3328} → C={3327,0,0}.
- Full length, q=8380417, ADDR_W=8, len=256, add, A[i]=i, B[i]=8380416 → C[0]=8380416, C[i]=i−1 for i>0.
  - Exactly 256 wr_en pulses and no gaps. done in cycle 259.
- len=0 → done in cycle 1, rd_en and wr_en never asserted. A start during busy is ignored: write count and done timing are unchanged.
- reset asserted during the cycle in which element 10 is written → all outputs are 0 in the same cycle and no further wr_en follows.
  - A following start with len=4 then completes correctly with done in cycle 7.
